commit_unit: RTL
================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameters: XLEN 32, operand width; LOG_REGS 32, architectural regs; PHY_REGS 64, physical regs (PRW = clog2(PHY_REGS), ARW = clog2(LOG_REGS)).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 commit_valid  in  1  ROB head entry is retire-eligible.
REQ-005 commit_ready  out  1  unit accepts the head entry this cycle; commit fires on commit_valid && commit_ready.
REQ-006 commit_arch_rd  in  ARW  destination arch reg; commit_new_prf / commit_old_prf  in  PRW  new/previous mapping.
REQ-007 commit_pc, commit_instr  in  32  PC and encoding; commit_is_store, commit_exception  in  1  entry flags.
REQ-008 fl_push_valid  out  1; fl_push_prf  out  PRW; fl_push_ready  in  1: free-list return, valid/ready.
REQ-009 st_commit_valid  out  1; st_commit_ready  in  1: release oldest store to memory.
REQ-010 flush_all  out  1  pipeline flush pulse; flush_pc  out  32  PC of the excepting instruction.
REQ-011 rrat_prf  out  LOG_REGS x PRW  retirement RAT contents, for rename recovery.

Function
REQ-012 At most one retirement per cycle, strictly in ROB order.
REQ-013 FSM states RUN, FLUSH, RECOVER; commit_ready is 0 outside RUN.
REQ-014 In RUN: commit_ready = slot_free && (!commit_is_store || commit_exception || st_commit_ready); slot_free = !fl_push_valid || fl_push_ready.
REQ-015 st_commit_valid = RUN && commit_valid && commit_is_store && !commit_exception && slot_free; combinational.
REQ-016 Normal fire (no exception, not store, arch_rd != 0): rrat[arch_rd] <= new_prf; fl_push_valid <= 1 and fl_push_prf <= old_prf next cycle.
REQ-017 fl_push_valid/fl_push_prf are held stable until fl_push_ready; fire and push-accept in the same cycle reload the slot with no bubble.
REQ-018 arch_rd == 0 or store fire: no RRAT update, no free-list push.
REQ-019 Exception fire: no RRAT update, no push, no store release; next cycle state FLUSH, flush_pc <= commit_pc.
REQ-020 FLUSH lasts exactly one cycle with flush_all = 1; then RECOVER.
REQ-021 RECOVER holds until fl_push_valid = 0, then returns to RUN; the minimum exception-to-next-commit gap is 2 cycles.
REQ-022 rrat_prf reflects registered state (updated the cycle after fire); rename rebuilds its free list from it after flush_all.
REQ-023 flush_all is 0 in every state other than FLUSH.

Reset
REQ-024 On rst: state RUN, rrat[i] = i for all i, fl_push_valid 0, fl_push_prf 0, flush_all 0, flush_pc 0; perf counter 0.
REQ-025 Reset asserted mid-operation discards any pending free-list push and any FLUSH/RECOVER state immediately.

Configuration
REQ-026 Macro COMMIT_PERF_EN: when defined, add output retired_count (64 bits) incremented on every fire, including stores and x0 writes, excluding exception fires.
REQ-027 Without COMMIT_PERF_EN: port and counter absent; all other behaviour identical.

Structure
REQ-028 Package ooo_pkg holds XLEN, LOG_REGS, PHY_REGS, arch_reg_t, phys_reg_t and commit_state_t enum {RUN, FLUSH, RECOVER}.
REQ-029 The RRAT is the sub-module commit_rrat (one write port, full parallel read, identity reset); commit_unit holds the FSM and free-list slot.

Verification
REQ-030 Fire rd=5 new=15 old=2 with fl_push_ready=1 -> next cycle rrat[5]=15, fl_push_valid=1 with prf=2 for one cycle.
REQ-031 Store (rd=7 new=19 old=12), st_commit_ready=0 for 3 cycles then 1 -> commit_ready=0 for 3 cycles, fires on 4th; rrat[7] unchanged, no push.
REQ-032 Back-to-back fires rd=5/new=15/old=2 then rd=6/new=18/old=7, fl_push_ready=0 for 2 cycles -> second fire stalls until first push accepted; pushes 2 then 7, in order.
REQ-033 Exception on pc=0x1004 -> flush_all=1 for exactly one cycle, flush_pc=0x1004, rrat unchanged, commit_ready=0 for 2 cycles.
REQ-034 Fire rd=0 new=20 old=3 -> rrat unchanged, no push; assert rst during a held push -> fl_push_valid=0 and rrat identity immediately.
REQ-035 With COMMIT_PERF_EN: 3 normal fires + 1 exception -> retired_count=3.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared widths, register-tag types and the commit FSM state encoding for the
// out-of-order retirement path.
package ooo_pkg;
    localparam int XLEN     = 32;
    localparam int LOG_REGS = 32;
    localparam int PHY_REGS = 64;
    localparam int ARW      = $clog2(LOG_REGS);
    localparam int PRW      = $clog2(PHY_REGS);

    typedef logic [ARW-1:0] arch_reg_t;
    typedef logic [PRW-1:0] phys_reg_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } commit_state_t;
endpackage

// File: rtl/commit_rrat.sv
// Retirement RAT: one write port, all entries read in parallel, identity mapping
// on reset so arch reg i starts in physical reg i.
module commit_rrat
    import ooo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  arch_reg_t               i_waddr,
    input  phys_reg_t               i_wdata,
    output logic [LOG_REGS*PRW-1:0] o_map
);
    phys_reg_t r_map [LOG_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOG_REGS; i++) begin
                r_map[i] <= PRW'(i);
            end
        end else if (i_we) begin
            r_map[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < LOG_REGS; g++) begin : g_flat
        assign o_map[g*PRW +: PRW] = r_map[g];
    end
endmodule

// File: rtl/commit_unit.sv
// In-order retirement: updates the RRAT, returns freed physical regs through a
// one-entry push slot, releases stores and sequences exception flushes.
// Optional perf counter retired_count is enabled with the macro COMMIT_PERF_EN.
module commit_unit
    import ooo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    commit_valid,
    output logic                    commit_ready,
    input  logic [ARW-1:0]          commit_arch_rd,
    input  logic [PRW-1:0]          commit_new_prf,
    input  logic [PRW-1:0]          commit_old_prf,
    input  logic [XLEN-1:0]         commit_pc,
    input  logic [31:0]             commit_instr,
    input  logic                    commit_is_store,
    input  logic                    commit_exception,
    output logic                    fl_push_valid,
    output logic [PRW-1:0]          fl_push_prf,
    input  logic                    fl_push_ready,
    output logic                    st_commit_valid,
    input  logic                    st_commit_ready,
    output logic                    flush_all,
    output logic [XLEN-1:0]         flush_pc,
`ifdef COMMIT_PERF_EN
    output logic [63:0]             retired_count,
`endif
    output logic [LOG_REGS*PRW-1:0] rrat_prf
);
    commit_state_t   r_state, w_state_next;
    logic            r_fl_valid;
    logic [PRW-1:0]  r_fl_prf;
    logic [XLEN-1:0] r_flush_pc;
    logic            w_slot_free, w_run, w_fire, w_fire_exc, w_fire_reg;
    logic            w_unused_instr;

    // The encoding is carried only for trace/debug further down the pipe.
    assign w_unused_instr = ^commit_instr;

    assign w_run        = (r_state == RUN);
    // A new push may load when the slot is empty or is being drained this cycle.
    assign w_slot_free  = !r_fl_valid || fl_push_ready;
    assign commit_ready = w_run && w_slot_free &&
                          (!commit_is_store || commit_exception || st_commit_ready);
    assign st_commit_valid = w_run && commit_valid && commit_is_store &&
                             !commit_exception && w_slot_free;

    assign w_fire     = commit_valid && commit_ready;
    assign w_fire_exc = w_fire && commit_exception;
    assign w_fire_reg = w_fire && !commit_exception && !commit_is_store &&
                        (commit_arch_rd != '0);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (w_fire_exc) w_state_next = FLUSH;
            FLUSH:   w_state_next = RECOVER;
            RECOVER: if (!r_fl_valid) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_fl_valid <= 1'b0;
            r_fl_prf   <= '0;
            r_flush_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire_reg) begin
                r_fl_valid <= 1'b1;
                r_fl_prf   <= commit_old_prf;
            end else if (fl_push_ready) begin
                r_fl_valid <= 1'b0;
            end
            if (w_fire_exc) begin
                r_flush_pc <= commit_pc;
            end
        end
    end

`ifdef COMMIT_PERF_EN
    logic [63:0] r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_fire && !commit_exception) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    assign retired_count = r_retired;
`endif

    assign fl_push_valid = r_fl_valid;
    assign fl_push_prf   = r_fl_prf;
    assign flush_all     = (r_state == FLUSH);
    assign flush_pc      = r_flush_pc;

    commit_rrat u_rrat (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_fire_reg),
        .i_waddr (commit_arch_rd),
        .i_wdata (commit_new_prf),
        .o_map   (rrat_prf)
    );
endmodule
